cla_addsub_seq: RTL and testbench

- Multi-precision add/subtract sequencer. It time-shares one 4-bit carry-lookahead add/sub slice across a WIDTH-bit operand pair, one nibble per clock, LSB nibble first.
- It sits between a requesting datapath (start/ready/done handshake) and the shared 4-bit slice.
- It owns operand capture, the inter-nibble carry/borrow chain, result assembly, and the carry and overflow flags.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla4_slice.sv | 37 +++
 rtl/cla_addsub_seq.sv | 128 ++++++++++++
 tb/tb_cla_addsub_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// =============================================================================
// cla_pkg : shared types, constants and helpers for the nibble-serial add/sub
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

package cla_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed overflow: like-signed operands yielding a result of the other sign.
  function automatic logic calc_ovf(input logic a_msb, input logic beff_msb,
                                    input logic res_msb);
    return (a_msb == beff_msb) && (res_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla4_slice.sv
// =============================================================================
// cla4_slice : combinational 4-bit carry-lookahead adder slice
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is a flat sum of generate/propagate products; no ripple.
  assign w_c1 = w_g[0] | (w_p[0] & cin);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s = w_p ^ {w_c3, w_c2, w_c1, cin};

endmodule

`default_nettype wire

// File: rtl/cla_addsub_seq.sv
// =============================================================================
// cla_addsub_seq : WIDTH-bit add/sub sequenced one nibble per clock, LSB first
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module cla_addsub_seq
  import cla_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int WIDTH   = SLICE_W * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_op_sub;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_res;
  logic               r_cout;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic               w_last;

  // Inversion is applied per nibble; carry-in is the chained carry, seeded
  // with op_sub only at capture so the borrow propagates across nibbles.
  assign w_sa   = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_sb   = r_b[r_idx*SLICE_W +: SLICE_W] ^ {SLICE_W{r_op_sub}};
  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  cla4_slice u_slice (
    .a    (w_sa),
    .b    (w_sb),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op_sub <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_res    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_op_sub <= op_sub;
            r_carry  <= op_sub;
            r_idx    <= '0;
          end
        end
        RUN: begin
          r_res[r_idx*SLICE_W +: SLICE_W] <= w_s;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= calc_ovf(r_a[WIDTH-1], r_b[WIDTH-1] ^ r_op_sub, w_s[SLICE_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign res  = r_res;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla_addsub_seq.sv
// =============================================================================
// tb_cla_addsub_seq : self-checking bench for the nibble-serial add/sub
// Rev 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_cla_addsub_seq;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op_sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready, busy, done, cout, ovf;
  logic [15:0] res;

  logic        start1 = 1'b0;
  logic        op1 = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        ready1, busy1, done1, cout1, ovf1;
  logic [3:0]  res1;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  bit          auto_push = 1'b0;
  exp_t        q[$];
  int          acc_log[$];

  cla_addsub_seq #(.NIBBLES(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .res(res), .cout(cout), .ovf(ovf)
  );

  cla_addsub_seq #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .res(res1), .cout(cout1), .ovf(ovf1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [15:0] be;
    logic [16:0] sum;
    exp_t        e;
    be     = y ^ {16{s}};
    sum    = {1'b0, x} + {1'b0, be} + 17'(s);
    e.res  = sum[15:0];
    e.cout = sum[16];
    e.ovf  = (x[15] == be[15]) && (sum[15] != x[15]);
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Accept logging / scoreboard push, and pop-and-compare on every done.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst && start && ready) begin
      acc_log.push_back(cyc);
      if (auto_push) q.push_back(model(a, b, op_sub));
    end
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("res", 32'(res), 32'(e.res));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input logic si,
                        input int exp_lat, input bit scramble);
    int n;
    n = 0;
    #1;
    while (!ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("ready_before_start", 32'(ready), 32'd1);
    @(negedge clk);
    a = ai; b = bi; op_sub = si; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    #1;
    while (!done && n < 20) begin
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom_range(0, 1));
      end
      @(negedge clk); #1; n++;
    end
    check("done_seen", 32'(done), 32'd1);
    if (exp_lat != 0) check("latency", 32'(n), 32'(exp_lat));
    if (scramble) begin
      a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom_range(0, 1));
    end
    @(negedge clk); #1;
    check("ready_after_done", 32'(ready), 32'd1);
  endtask

  task automatic run1(input logic [3:0] ai, input logic [3:0] bi, input logic si,
                      input logic [3:0] er, input logic ec, input logic eo);
    int n;
    @(negedge clk);
    a1 = ai; b1 = bi; op1 = si; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    #1;
    while (!done1 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    check("n1_done_seen", 32'(done1), 32'd1);
    check("n1_latency", 32'(n), 32'd2);
    check("n1_res", 32'(res1), 32'(er));
    check("n1_cout", 32'(cout1), 32'(ec));
    check("n1_ovf", 32'(ovf1), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
    tbl[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[2] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    rst = 1'b0;

    // Directed vectors with hand-derived expectations.
    auto_push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      q.push_back('{tbl[i].res, tbl[i].cout, tbl[i].ovf});
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, 5, 1'b0);
    end

    // Operands wiggling during RUN/DONE must not disturb the captured op.
    q.push_back('{16'h0002, 1'b1, 1'b0});
    run_op(16'h0007, 16'h0005, 1'b1, 5, 1'b1);

    // start held high: accepted only in IDLE, one op every 6 cycles.
    auto_push = 1'b1;
    acc_log.delete();
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; op_sub = 1'b0; start = 1'b1;
    repeat (14) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_accepts", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() >= 3) begin
      check("period_0_1", 32'(acc_log[1] - acc_log[0]), 32'd6);
      check("period_1_2", 32'(acc_log[2] - acc_log[1]), 32'd6);
    end
    check("held_drained", 32'(q.size()), 32'd0);

    // Reset after two RUN edges abandons the operation silently.
    auto_push = 1'b0;
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_res", 32'(res), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); #1;
      check("midrst_no_done", 32'(done), 32'd0);
    end
    q.push_back('{16'h0100, 1'b0, 1'b0});
    run_op(16'h00FF, 16'h0001, 1'b0, 5, 1'b0);

    // Random vectors against the reference model.
    auto_push = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0);
    end
    auto_push = 1'b0;

    // Single-nibble build.
    run1(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    run1(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);
    run1(4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
